// File: rtl/wb_regfile.sv
// Writeback stage + 4-entry register file: selects the WB value, commits it, tracks WWD output, retired count and sticky halt.
// Read ports and WB bus are combinational with write-through bypass; committed state updates one edge later; no backpressure.
module wb_regfile #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [WORD_SIZE-1:0] MemData_in,
    input  logic [WORD_SIZE-1:0] ALU_Result_in,
    input  logic [1:0]           rd_in,
    input  logic                 MemtoReg_in,
    input  logic                 RegWrite_in,
    input  logic                 is_wwd_in,
    input  logic                 is_done_in,
    input  logic [1:0]           rs1_addr,
    input  logic [1:0]           rs2_addr,
    output logic [WORD_SIZE-1:0] rs1_data,
    output logic [WORD_SIZE-1:0] rs2_data,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic [1:0]           wb_rd,
    output logic                 wb_en,
    output logic [WORD_SIZE-1:0] output_port,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 is_halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic [WORD_SIZE-1:0] out_port_q, out_port_d;
    logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;
    logic                 commit;

    assign is_halted = (state_q == ST_HALTED);
    assign commit    = valid_in & ~is_halted;

    assign wb_data = MemtoReg_in ? MemData_in : ALU_Result_in;
    assign wb_rd   = rd_in;
    assign wb_en   = commit & RegWrite_in;

    // Write-through so decode sees this cycle's writeback without a stall
    assign rs1_data = (wb_en && rs1_addr == rd_in) ? wb_data : regs_q[rs1_addr];
    assign rs2_data = (wb_en && rs2_addr == rd_in) ? wb_data : regs_q[rs2_addr];

    assign output_port = out_port_q;
    assign num_inst    = num_inst_q;

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        out_port_d = out_port_q;
        num_inst_d = num_inst_q;
        if (commit) begin
            if (RegWrite_in) begin
                regs_d[rd_in] = wb_data;
            end
            if (is_wwd_in) begin
                out_port_d = ALU_Result_in;
            end
            num_inst_d = num_inst_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
            if (is_done_in) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            out_port_q <= '0;
            num_inst_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            out_port_q <= out_port_d;
            num_inst_q <= num_inst_d;
            regs_q     <= regs_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus random stimulus for wb_regfile, checked against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [15:0] MemData_in;
    logic [15:0] ALU_Result_in;
    logic [1:0]  rd_in;
    logic        MemtoReg_in;
    logic        RegWrite_in;
    logic        is_wwd_in;
    logic        is_done_in;
    logic [1:0]  rs1_addr;
    logic [1:0]  rs2_addr;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] wb_data;
    logic [1:0]  wb_rd;
    logic        wb_en;
    logic [15:0] output_port;
    logic [15:0] num_inst;
    logic        is_halted;

    wb_regfile #(.WORD_SIZE(16), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .MemData_in(MemData_in), .ALU_Result_in(ALU_Result_in), .rd_in(rd_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .is_wwd_in(is_wwd_in), .is_done_in(is_done_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
        .output_port(output_port), .num_inst(num_inst), .is_halted(is_halted)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [15:0] m_regs [4];
    logic [15:0] m_out;
    logic [15:0] m_cnt;
    logic        m_halt;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] md, input logic [15:0] alu,
                         input logic [1:0] rd, input logic mtr, input logic rw,
                         input logic wwd, input logic dn, input logic [1:0] a1,
                         input logic [1:0] a2, input logic rst);
        valid_in = v; MemData_in = md; ALU_Result_in = alu; rd_in = rd;
        MemtoReg_in = mtr; RegWrite_in = rw; is_wwd_in = wwd; is_done_in = dn;
        rs1_addr = a1; rs2_addr = a2; reset = rst;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
        m_out = 16'h0000; m_cnt = 16'h0000; m_halt = 1'b0;
    endtask

    // One clock: combinational checks mid-cycle, model update at the edge, registered checks after.
    task automatic cyc();
        logic [15:0] ew, e1, e2;
        logic        ee;
        @(negedge clk);
        ew = MemtoReg_in ? MemData_in : ALU_Result_in;
        ee = valid_in && RegWrite_in && !m_halt;
        e1 = (ee && rs1_addr == rd_in) ? ew : m_regs[rs1_addr];
        e2 = (ee && rs2_addr == rd_in) ? ew : m_regs[rs2_addr];
        chk("wb_data", wb_data, ew);
        chk("wb_en", {15'd0, wb_en}, {15'd0, ee});
        chk("wb_rd", {14'd0, wb_rd}, {14'd0, rd_in});
        chk("rs1_data", rs1_data, e1);
        chk("rs2_data", rs2_data, e2);
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (valid_in && !m_halt) begin
            if (RegWrite_in) m_regs[rd_in] = ew;
            if (is_wwd_in) m_out = ALU_Result_in;
            m_cnt = m_cnt + 16'd1;
            if (is_done_in) m_halt = 1'b1;
        end
        #1;
        chk("output_port", output_port, m_out);
        chk("num_inst", num_inst, m_cnt);
        chk("is_halted", {15'd0, is_halted}, {15'd0, m_halt});
    endtask

    initial begin
        // Reset held two cycles
        drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1);
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        chk("rst_num_inst", num_inst, 16'h0000);
        chk("rst_output_port", output_port, 16'h0000);
        chk("rst_is_halted", {15'd0, is_halted}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'(i), 2'(3 - i), 0);
            cyc();
        end

        // ALU write with same-cycle bypass on rs1, then array read through a bubble
        drive(1, 16'hDEAD, 16'h1234, 2'd2, 0, 1, 0, 0, 2'd2, 2'd2, 0);
        cyc();
        drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd2, 2'd0, 0);
        cyc();
        chk("alu_reg2", rs1_data, 16'h1234);
        chk("alu_cnt", num_inst, 16'h0001);

        // Load writeback: memory data wins over ALU value
        drive(1, 16'hBEEF, 16'h0001, 2'd3, 1, 1, 0, 0, 2'd3, 2'd2, 0);
        cyc();
        drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd3, 2'd3, 0);
        cyc();
        chk("load_reg3", rs1_data, 16'hBEEF);

        // WWD, then a bubble carrying a stray WWD flag
        drive(1, 16'h0, 16'h00A5, 2'd1, 0, 0, 1, 0, 2'd1, 2'd3, 0);
        cyc();
        chk("wwd_out", output_port, 16'h00A5);
        drive(0, 16'h0, 16'h5A5A, 2'd1, 0, 1, 1, 1, 2'd1, 2'd0, 0);
        cyc();
        chk("bubble_out", output_port, 16'h00A5);
        chk("bubble_cnt", num_inst, 16'h0003);

        // Halt, then a frozen write attempt, then reset clears everything
        drive(1, 16'h0, 16'h0042, 2'd2, 0, 0, 0, 1, 2'd0, 2'd1, 0);
        cyc();
        chk("hlt_cnt", num_inst, 16'h0004);
        drive(1, 16'h0, 16'h7777, 2'd0, 0, 1, 1, 0, 2'd0, 2'd0, 0);
        cyc();
        chk("halt_reg0", rs1_data, 16'h0000);
        chk("halt_cnt", num_inst, 16'h0004);
        drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd3, 2'd2, 1);
        cyc();
        drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd3, 2'd2, 0);
        cyc();
        chk("post_rst_reg3", rs1_data, 16'h0000);

        // Random traffic with occasional halts and resets
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 40) == 0), 2'($urandom), 2'($urandom),
                  1'($urandom_range(0, 30) == 0));
            cyc();
        end

        // Counter wrap: reset, 65535 plain commits, then one more
        drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1);
        cyc();
        drive(1, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        repeat (65535) @(posedge clk);
        #1;
        m_cnt = 16'hFFFF;
        chk("cnt_ffff", num_inst, 16'hFFFF);
        cyc();
        chk("cnt_wrap", num_inst, 16'h0000);

        // Reset wins over a same-cycle write
        drive(1, 16'h0, 16'h5555, 2'd1, 0, 1, 1, 0, 2'd1, 2'd0, 1);
        cyc();
        drive(0, 16'h0, 16'h0, 2'd0, 0, 0, 0, 0, 2'd1, 2'd1, 0);
        cyc();
        chk("rst_prio_reg1", rs1_data, 16'h0000);
        chk("rst_prio_out", output_port, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
